imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/loader_pkg.sv | 18 +
 rtl/imem_write_port.sv | 27 ++
 rtl/imem_loader.sv | 92 +++++++++
 tb/tb_imem_loader.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared loader constants, state encoding and alignment helper
package loader_pkg;
    localparam int ADDR_W = 9;
    localparam int MEM_BYTES = 512;
    localparam logic [7:0] PAD_BYTE = 8'h00;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        PAD,
        DONE,
        ERROR
    } state_t;

    function automatic logic word_aligned(input logic [1:0] low);
        return low == 2'b00;
    endfunction
endpackage

// File: rtl/imem_write_port.sv
// rtl/imem_write_port.sv - registered byte-write stage shared by load and pad paths
module imem_write_port #(
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata
);
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_we <= wr_en;
            if (wr_en) begin
                mem_addr  <= wr_addr;
                mem_wdata <= wr_data;
            end
        end
    end
endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - streams a program into instruction memory, pads to a word, holds the CPU meanwhile
module imem_loader #(
    parameter int ADDR_W    = loader_pkg::ADDR_W,
    parameter int MEM_BYTES = loader_pkg::MEM_BYTES
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    input  logic              byte_last,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_error,
    output logic [ADDR_W:0]   byte_count
);
    import loader_pkg::*;

    localparam logic [ADDR_W:0] ONE       = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W+1)'(MEM_BYTES - 1);

    state_t          state, state_nxt;
    logic [ADDR_W:0] count, count_nxt;
    logic            wr_en;
    logic [7:0]      wr_data;

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
        end
    end

    // count doubles as the write address; it stops at MEM_BYTES so the address never wraps
    always_comb begin
        state_nxt = state;
        count_nxt = count;
        wr_en     = 1'b0;
        wr_data   = byte_data;
        case (state)
            IDLE, DONE, ERROR: begin
                if (start) begin
                    state_nxt = LOAD;
                    count_nxt = '0;
                end
            end
            LOAD: begin
                if (byte_valid) begin
                    wr_en     = 1'b1;
                    count_nxt = count + ONE;
                    if (byte_last)
                        state_nxt = word_aligned(count_nxt[1:0]) ? DONE : PAD;
                    else if (count == LAST_ADDR)
                        state_nxt = ERROR;
                end
            end
            PAD: begin
                wr_en     = 1'b1;
                wr_data   = PAD_BYTE;
                count_nxt = count + ONE;
                if (word_aligned(count_nxt[1:0]))
                    state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    imem_write_port #(.ADDR_W(ADDR_W)) u_write_port (
        .clk       (clk),
        .Reset     (Reset),
        .wr_en     (wr_en),
        .wr_addr   (count[ADDR_W-1:0]),
        .wr_data   (wr_data),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata)
    );

    // hold stays up through the final registered write, releasing the CPU the cycle after it
    assign cpu_hold   = (state != DONE) | mem_we;
    assign byte_ready = (state == LOAD);
    assign load_done  = (state == DONE);
    assign load_error = (state == ERROR);
    assign byte_count = count;
endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed and randomized checks of imem_loader against a program-image model
module tb_imem_loader;
    localparam int AW  = 9;
    localparam int CAP = 512;

    logic          clk = 1'b0;
    logic          Reset;
    logic          start;
    logic          byte_valid;
    logic [7:0]    byte_data;
    logic          byte_last;
    logic          byte_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic          cpu_hold;
    logic          load_done;
    logic          load_error;
    logic [AW:0]   byte_count;

    int checks   = 0;
    int failures = 0;

    logic [16:0] obs_q[$];
    logic [16:0] exp_q[$];
    logic [7:0]  offered_q[$];
    logic [7:0]  fixed_prog[8] = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};

    imem_loader dut (
        .clk        (clk),
        .Reset      (Reset),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_last  (byte_last),
        .byte_ready (byte_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cpu_hold   (cpu_hold),
        .load_done  (load_done),
        .load_error (load_error),
        .byte_count (byte_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_we === 1'b1)
            obs_q.push_back({mem_addr, mem_wdata});
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic offer(input logic [7:0] d, input bit last, output bit acc);
        bit r;
        acc        = 1'b0;
        byte_valid = 1'b1;
        byte_data  = d;
        byte_last  = last;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            r = byte_ready;
            @(posedge clk);
            #1;
            if (r) begin
                acc = 1'b1;
                break;
            end
        end
        byte_valid = 1'b0;
        byte_last  = 1'b0;
    endtask

    // Expected image: first min(n, CAP) offered bytes in order, then zero pad up to a word if terminated.
    task automatic build_expected(input int n, input bit flag_last);
        int m;
        m = (n > CAP) ? CAP : n;
        exp_q.delete();
        for (int a = 0; a < m; a++)
            exp_q.push_back({AW'(a), offered_q[a]});
        if (flag_last)
            while (exp_q.size() % 4 != 0)
                exp_q.push_back({AW'(exp_q.size()), 8'h00});
    endtask

    task automatic run_load(input string name, input int n, input bit flag_last, input bit use_fixed,
                            input bit toggle, input bit start_mid, input bit reload_check);
        bit         acc;
        bit         ended;
        int         accepted;
        logic [7:0] d;
        logic [16:0] o;
        obs_q.delete();
        offered_q.delete();
        accepted = 0;
        pulse_start();
        if (reload_check) begin
            check({name, ".reload_done"}, 32'(load_done), 32'd0);
            check({name, ".reload_hold"}, 32'(cpu_hold), 32'd1);
            check({name, ".reload_count"}, 32'(byte_count), 32'd0);
        end
        for (int i = 0; i < n; i++) begin
            d = use_fixed ? fixed_prog[i] : 8'($urandom);
            offered_q.push_back(d);
            offer(d, flag_last && (i == n - 1), acc);
            if (acc)
                accepted++;
            if (toggle && i < n - 1) begin
                if (start_mid && i == n / 2)
                    start = 1'b1;
                @(posedge clk);
                #1;
                start = 1'b0;
            end
        end
        build_expected(n, flag_last);
        check({name, ".accepted"}, 32'(accepted), 32'((n > CAP) ? CAP : n));
        ended = 1'b0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (load_done === 1'b1 || load_error === 1'b1) begin
                ended = 1'b1;
                break;
            end
        end
        check({name, ".ended"}, 32'(ended), 32'd1);
        check({name, ".load_done"}, 32'(load_done), 32'(flag_last));
        check({name, ".load_error"}, 32'(load_error), 32'(!flag_last));
        @(negedge clk);
        check({name, ".cpu_hold_after"}, 32'(cpu_hold), 32'(!flag_last));
        check({name, ".mem_we_after"}, 32'(mem_we), 32'd0);
        check({name, ".byte_ready"}, 32'(byte_ready), 32'd0);
        check({name, ".byte_count"}, 32'(byte_count), 32'(exp_q.size()));
        #1;
        check({name, ".writes"}, 32'(obs_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            o = (i < obs_q.size()) ? obs_q[i] : 17'bx;
            check($sformatf("%s.write[%0d]", name, i), 32'(o), 32'(exp_q[i]));
        end
    endtask

    initial begin
        bit acc;
        Reset      = 1'b1;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        byte_last  = 1'b0;
        #12;
        check("rst.mem_we", 32'(mem_we), 32'd0);
        check("rst.mem_addr", 32'(mem_addr), 32'd0);
        check("rst.mem_wdata", 32'(mem_wdata), 32'd0);
        check("rst.byte_count", 32'(byte_count), 32'd0);
        check("rst.cpu_hold", 32'(cpu_hold), 32'd1);
        check("rst.byte_ready", 32'(byte_ready), 32'd0);
        check("rst.load_done", 32'(load_done), 32'd0);
        check("rst.load_error", 32'(load_error), 32'd0);
        @(negedge clk);
        Reset = 1'b0;
        @(posedge clk);
        #1;
        check("idle.byte_ready", 32'(byte_ready), 32'd0);

        run_load("prog8", 8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        run_load("pad6", 6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++)
            run_load($sformatf("rand%0d", k), int'($urandom_range(1, 21)), 1'b1, 1'b0,
                     1'($urandom_range(0, 1)), 1'b0, 1'b1);
        run_load("toggle", 9, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        run_load("overflow", CAP + 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        obs_q.delete();
        pulse_start();
        for (int i = 0; i < 3; i++)
            offer(8'($urandom), 1'b0, acc);
        Reset = 1'b1;
        #1;
        check("abort.mem_we", 32'(mem_we), 32'd0);
        check("abort.byte_count", 32'(byte_count), 32'd0);
        check("abort.cpu_hold", 32'(cpu_hold), 32'd1);
        check("abort.byte_ready", 32'(byte_ready), 32'd0);
        @(negedge clk);
        Reset = 1'b0;
        #1;
        obs_q.delete();
        offer(8'h5a, 1'b0, acc);
        check("abort.needs_start", 32'(acc), 32'd0);
        check("abort.no_writes", 32'(obs_q.size()), 32'd0);
        run_load("after_abort", 4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
